// File: rtl/mips_alu_pkg.sv
// Shared ALU function codes, muldiv opcodes and sequencer state encoding
// for the MIPS EX stage.
package mips_alu_pkg;

    localparam logic [5:0] FunctAdd   = 6'b100000;
    localparam logic [5:0] FunctSub   = 6'b100010;
    localparam logic [5:0] FunctSlt   = 6'b101010;
    localparam logic [5:0] FunctMult  = 6'b011000;
    localparam logic [5:0] FunctMultu = 6'b011001;
    localparam logic [5:0] FunctDiv   = 6'b011010;
    localparam logic [5:0] FunctDivu  = 6'b011011;

    typedef enum logic [2:0] {
        StIdle,
        StPrepA,
        StPrepB,
        StIter,
        StFixLo,
        StFixHi
    } muldiv_state_e;

    // Carry out of the ALU adder, rebuilt from operand and result MSBs.
    function automatic logic alu_carry(input logic a_msb, input logic b_msb,
                                       input logic out_msb);
        return (a_msb & b_msb) | ((a_msb ^ b_msb) & ~out_msb);
    endfunction

endpackage

// File: rtl/muldiv_alu_sequencer_step.sv
// One shift-add multiply or restoring divide iteration built around the shared ALU.
module muldiv_step
    import mips_alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_acc_hi,
    input  logic [WIDTH-1:0] i_acc_lo,
    input  logic [WIDTH-1:0] i_mag_a,
    input  logic [WIDTH-1:0] i_mag_b,
    input  logic             i_is_div,
    input  logic [WIDTH-1:0] i_alu_dataOut,
    output logic [WIDTH-1:0] o_alu_dataA,
    output logic [WIDTH-1:0] o_alu_dataB,
    output logic [5:0]       o_alu_Signal,
    output logic [WIDTH-1:0] o_next_hi,
    output logic [WIDTH-1:0] o_next_lo
);

    logic [WIDTH-1:0] w_rem;
    logic             w_carry;
    logic             w_ok;

    assign w_rem = {i_acc_hi[WIDTH-2:0], i_acc_lo[WIDTH-1]};

    always_comb begin
        o_alu_dataA  = i_acc_hi;
        o_alu_dataB  = i_mag_a;
        o_alu_Signal = FunctAdd;
        o_next_hi    = i_acc_hi;
        o_next_lo    = i_acc_lo;
        w_carry      = 1'b0;
        w_ok         = 1'b0;
        if (i_is_div) begin
            o_alu_dataA  = w_rem;
            o_alu_dataB  = i_mag_b;
            o_alu_Signal = FunctSub;
            w_carry      = alu_carry(w_rem[WIDTH-1], ~i_mag_b[WIDTH-1],
                                     i_alu_dataOut[WIDTH-1]);
            // A remainder bit shifted out of acc_hi always exceeds the divisor.
            w_ok         = i_acc_hi[WIDTH-1] | w_carry;
            o_next_hi    = w_ok ? i_alu_dataOut : w_rem;
            o_next_lo    = {i_acc_lo[WIDTH-2:0], w_ok};
        end else begin
            w_carry = alu_carry(i_acc_hi[WIDTH-1], i_mag_a[WIDTH-1],
                                i_alu_dataOut[WIDTH-1]);
            if (i_acc_lo[0]) begin
                o_next_hi = {w_carry, i_alu_dataOut[WIDTH-1:1]};
                o_next_lo = {i_alu_dataOut[0], i_acc_lo[WIDTH-1:1]};
            end else begin
                o_next_hi = {1'b0, i_acc_hi[WIDTH-1:1]};
                o_next_lo = {i_acc_hi[0], i_acc_lo[WIDTH-1:1]};
            end
        end
    end

endmodule

// File: rtl/muldiv_alu_sequencer.sv
// MULT/MULTU/DIV/DIVU sequencer: borrows the EX-stage ALU for 36 cycles and
// commits the 64-bit result into HI/LO.
module muldiv_alu_sequencer
    import mips_alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] srcA,
    input  logic [WIDTH-1:0] srcB,
    input  logic [WIDTH-1:0] ex_dataA,
    input  logic [WIDTH-1:0] ex_dataB,
    input  logic [5:0]       ex_Signal,
    output logic [WIDTH-1:0] alu_dataA,
    output logic [WIDTH-1:0] alu_dataB,
    output logic [5:0]       alu_Signal,
    input  logic [WIDTH-1:0] alu_dataOut,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    muldiv_state_e    r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_mag_a;
    logic [WIDTH-1:0] r_mag_b;
    logic [WIDTH-1:0] r_acc_hi;
    logic [WIDTH-1:0] r_acc_lo;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [4:0]       r_cnt;
    logic             r_signed;
    logic             r_is_div;
    logic             r_lo_zero;
    logic             r_done;

    logic             w_funct_ok;
    logic             w_fix_sign;
    logic             w_fix_hi;
    logic [WIDTH-1:0] w_mag_a;
    logic [WIDTH-1:0] w_mag_b;
    logic [WIDTH-1:0] w_hi_final;
    logic [WIDTH-1:0] w_step_a;
    logic [WIDTH-1:0] w_step_b;
    logic [5:0]       w_step_sig;
    logic [WIDTH-1:0] w_next_hi;
    logic [WIDTH-1:0] w_next_lo;

    assign w_funct_ok = funct inside {FunctMult, FunctMultu, FunctDiv, FunctDivu};
    assign w_fix_sign = r_signed & (r_a[WIDTH-1] ^ r_b[WIDTH-1]);
    // Remainder takes the dividend's sign; the product/quotient takes the XOR.
    assign w_fix_hi   = r_is_div ? (r_signed & r_a[WIDTH-1]) : w_fix_sign;
    assign w_mag_a    = (r_signed & r_a[WIDTH-1]) ? alu_dataOut : r_a;
    assign w_mag_b    = (r_signed & r_b[WIDTH-1]) ? alu_dataOut : r_b;
    assign w_hi_final = w_fix_hi ? alu_dataOut : r_acc_hi;

    muldiv_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .i_acc_hi      (r_acc_hi),
        .i_acc_lo      (r_acc_lo),
        .i_mag_a       (r_mag_a),
        .i_mag_b       (r_mag_b),
        .i_is_div      (r_is_div),
        .i_alu_dataOut (alu_dataOut),
        .o_alu_dataA   (w_step_a),
        .o_alu_dataB   (w_step_b),
        .o_alu_Signal  (w_step_sig),
        .o_next_hi     (w_next_hi),
        .o_next_lo     (w_next_lo)
    );

    always_comb begin
        alu_dataA  = ex_dataA;
        alu_dataB  = ex_dataB;
        alu_Signal = ex_Signal;
        unique case (r_state)
            StPrepA: begin
                alu_dataA  = '0;
                alu_dataB  = r_a;
                alu_Signal = FunctSub;
            end
            StPrepB: begin
                alu_dataA  = '0;
                alu_dataB  = r_b;
                alu_Signal = FunctSub;
            end
            StIter: begin
                alu_dataA  = w_step_a;
                alu_dataB  = w_step_b;
                alu_Signal = w_step_sig;
            end
            StFixLo: begin
                alu_dataA  = '0;
                alu_dataB  = r_acc_lo;
                alu_Signal = FunctSub;
            end
            StFixHi: begin
                if (r_is_div) begin
                    alu_dataA  = '0;
                    alu_dataB  = r_acc_hi;
                    alu_Signal = FunctSub;
                end else begin
                    // Upper half of a 64-bit negate: ~hi plus the borrow from lo.
                    alu_dataA  = ~r_acc_hi;
                    alu_dataB  = {{(WIDTH-1){1'b0}}, r_lo_zero};
                    alu_Signal = FunctAdd;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= StIdle;
            r_a       <= '0;
            r_b       <= '0;
            r_mag_a   <= '0;
            r_mag_b   <= '0;
            r_acc_hi  <= '0;
            r_acc_lo  <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_cnt     <= '0;
            r_signed  <= 1'b0;
            r_is_div  <= 1'b0;
            r_lo_zero <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (start && w_funct_ok) begin
                        r_a      <= srcA;
                        r_b      <= srcB;
                        r_signed <= ~funct[0];
                        r_is_div <= funct[1];
                        r_state  <= StPrepA;
                    end
                end
                StPrepA: begin
                    r_mag_a  <= w_mag_a;
                    r_acc_hi <= '0;
                    if (r_is_div) begin
                        r_acc_lo <= w_mag_a;
                    end
                    r_state <= StPrepB;
                end
                StPrepB: begin
                    r_mag_b <= w_mag_b;
                    if (!r_is_div) begin
                        r_acc_lo <= w_mag_b;
                    end
                    r_cnt   <= '0;
                    r_state <= StIter;
                end
                StIter: begin
                    r_acc_hi <= w_next_hi;
                    r_acc_lo <= w_next_lo;
                    r_cnt    <= r_cnt + 5'd1;
                    if (r_cnt == 5'd31) begin
                        r_state <= StFixLo;
                    end
                end
                StFixLo: begin
                    r_lo_zero <= (r_acc_lo == '0);
                    if (w_fix_sign) begin
                        r_acc_lo <= alu_dataOut;
                    end
                    r_state <= StFixHi;
                end
                StFixHi: begin
                    r_acc_hi <= w_hi_final;
                    r_hi     <= w_hi_final;
                    r_lo     <= r_acc_lo;
                    r_done   <= 1'b1;
                    r_state  <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign busy = (r_state != StIdle);
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: tb/tb_muldiv_alu_sequencer.sv
// Scoreboard bench: randomized and directed muldiv ops against a plain-arithmetic model.
module tb_muldiv_alu_sequencer;
    import mips_alu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [5:0]  funct;
    logic [31:0] srcA, srcB;
    logic [31:0] ex_dataA, ex_dataB;
    logic [5:0]  ex_Signal;
    logic [31:0] alu_dataA, alu_dataB, alu_dataOut;
    logic [5:0]  alu_Signal;
    logic        busy, done;
    logic [31:0] hi, lo;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          e0;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   busy_run = 0;

    muldiv_alu_sequencer #(
        .WIDTH(32)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .funct       (funct),
        .srcA        (srcA),
        .srcB        (srcB),
        .ex_dataA    (ex_dataA),
        .ex_dataB    (ex_dataB),
        .ex_Signal   (ex_Signal),
        .alu_dataA   (alu_dataA),
        .alu_dataB   (alu_dataB),
        .alu_Signal  (alu_Signal),
        .alu_dataOut (alu_dataOut),
        .busy        (busy),
        .done        (done),
        .hi          (hi),
        .lo          (lo)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Shared EX-stage ALU.
    always_comb begin
        alu_dataOut = '0;
        case (alu_Signal)
            FunctAdd: alu_dataOut = alu_dataA + alu_dataB;
            FunctSub: alu_dataOut = alu_dataA - alu_dataB;
            FunctSlt: alu_dataOut = {31'b0, $signed(alu_dataA) < $signed(alu_dataB)};
            default:  alu_dataOut = '0;
        endcase
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Returns {HI, LO}.
    function automatic logic [63:0] ref_model(input logic [5:0] f, input logic [31:0] a,
                                              input logic [31:0] b);
        longint      sa, sbv;
        logic [63:0] q, r;
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        case (f)
            FunctMult:  return 64'(sa * sbv);
            FunctMultu: return {32'b0, a} * {32'b0, b};
            FunctDivu: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
            default: begin
                if (b == 0) return {a, a[31] ? 32'h0000_0001 : 32'hFFFF_FFFF};
                q = 64'(sa / sbv);
                r = 64'(sa % sbv);
                return {r[31:0], q[31:0]};
            end
        endcase
    endfunction

    // Monitor: pops the scoreboard whenever the DUT pulses done.
    always @(negedge clk) begin
        exp_t e;
        if (done) begin
            if (sb.size() == 0) begin
                check("spurious_done", 64'(done), 64'(0));
            end else begin
                e = sb.pop_front();
                check("hi", 64'(hi), 64'(e.hi));
                check("lo", 64'(lo), 64'(e.lo));
                check("done_cycle", 64'(cyc - e.e0 + 1), 64'(37));
                check("busy_cycles", 64'(busy_run), 64'(36));
            end
        end
        if (busy) busy_run = busy_run + 1;
        else busy_run = 0;
    end

    task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        logic [63:0] m;
        int          n;
        n = 0;
        @(negedge clk);
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            check("idle_timeout", 64'(busy), 64'(0));
            return;
        end
        start     = 1'b1;
        funct     = f;
        srcA      = a;
        srcB      = b;
        ex_dataA  = $urandom;
        ex_dataB  = $urandom;
        ex_Signal = 6'($urandom);
        @(posedge clk);
        #1;
        m    = ref_model(f, a, b);
        e.hi = m[63:32];
        e.lo = m[31:0];
        e.e0 = cyc;
        sb.push_back(e);
        start = 1'b0;
        srcA  = $urandom;
        srcB  = $urandom;
    endtask

    task automatic drain();
        for (int i = 0; i < 100; i++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
        end
        if (sb.size() != 0) begin
            check("drain_timeout", 64'(sb.size()), 64'(0));
            sb.delete();
        end
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'h0000_0001;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'($urandom_range(0, 100));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [5:0]  ops [4];
        logic [31:0] ra, rb;
        ops[0] = FunctMult;
        ops[1] = FunctMultu;
        ops[2] = FunctDiv;
        ops[3] = FunctDivu;

        reset     = 1'b1;
        start     = 1'b0;
        funct     = '0;
        srcA      = '0;
        srcB      = '0;
        ex_dataA  = '0;
        ex_dataB  = '0;
        ex_Signal = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_busy", 64'(busy), 64'(0));
        check("reset_done", 64'(done), 64'(0));
        check("reset_hi", 64'(hi), 64'(0));
        check("reset_lo", 64'(lo), 64'(0));
        reset = 1'b0;

        ex_dataA  = 32'd3;
        ex_dataB  = 32'd4;
        ex_Signal = FunctAdd;
        #1;
        check("pass_dataA", 64'(alu_dataA), 64'(3));
        check("pass_dataB", 64'(alu_dataB), 64'(4));
        check("pass_signal", 64'(alu_Signal), 64'(FunctAdd));

        @(negedge clk);
        start = 1'b1;
        funct = FunctAdd;
        @(posedge clk);
        #1;
        check("bad_funct_busy", 64'(busy), 64'(0));
        start = 1'b0;

        issue(FunctMultu, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        drain();
        issue(FunctMult, 32'hFFFF_FFFD, 32'h0000_0007);
        drain();
        issue(FunctMult, 32'h0000_0000, 32'h8000_0000);
        drain();
        issue(FunctDiv, 32'hFFFF_FFF9, 32'h0000_0002);
        drain();
        issue(FunctDivu, 32'd64, 32'd7);
        drain();
        issue(FunctDivu, 32'h1234_5678, 32'h0000_0000);
        drain();
        issue(FunctDiv, 32'hFFFF_FFF0, 32'h0000_0000);
        drain();
        issue(FunctDiv, 32'h8000_0000, 32'hFFFF_FFFF);
        drain();

        // Re-asserted start while busy must not disturb the operation in flight.
        issue(FunctMultu, 32'd1234, 32'd5678);
        repeat (5) begin
            @(negedge clk);
            start = 1'b1;
            funct = FunctDiv;
            srcA  = $urandom;
            srcB  = $urandom;
        end
        @(negedge clk);
        start = 1'b0;
        drain();

        // Reset during ITER cycle 10 abandons the operation.
        issue(FunctMultu, 32'hFFFF_0000, 32'h0001_2345);
        repeat (11) @(posedge clk);
        @(negedge clk);
        reset     = 1'b1;
        ex_dataA  = 32'hA5A5_0001;
        ex_dataB  = 32'h0000_5A5A;
        ex_Signal = FunctSub;
        @(posedge clk);
        #1;
        sb.delete();
        check("midreset_busy", 64'(busy), 64'(0));
        check("midreset_done", 64'(done), 64'(0));
        check("midreset_hi", 64'(hi), 64'(0));
        check("midreset_lo", 64'(lo), 64'(0));
        check("midreset_alu_a", 64'(alu_dataA), 64'(32'hA5A5_0001));
        check("midreset_alu_b", 64'(alu_dataB), 64'(32'h0000_5A5A));
        check("midreset_alu_sig", 64'(alu_Signal), 64'(FunctSub));
        reset = 1'b0;
        issue(FunctMultu, 32'd3, 32'd5);
        drain();

        for (int i = 0; i < 40; i++) begin
            ra = pick_operand();
            rb = pick_operand();
            issue(ops[$urandom_range(0, 3)], ra, rb);
            if ($urandom_range(0, 3) == 0) drain();
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
